ring_buffer_drain: RTL
======================

// Module: ring_buffer_drain
// PURPOSE
//  Read side of the ring-router input buffer; counterpart of the empty-slot allocator on the write side.
//  Scans slot valid bits (MSB of each slot) and picks an occupied slot round-robin.
//  Registers the packet onto a valid/ready output port toward the switch/ejection stage.
//  Pulses a per-slot clear so the buffer frees the slot for the allocator.
// PARAMETERS
//  BUFFER_SIZE  4   number of slots; must equal 2**PTR_LEN (elaboration error otherwise)
//  PACKET_SIZE  49  slot width; bit PACKET_SIZE-1 = valid flag
//  PTR_LEN      2   slot index width
// PORTS
//  clk        in   1                        clock, all logic rising-edge
//  rst_n      in   1                        asynchronous active-low reset
//  buf_flat   in   BUFFER_SIZE*PACKET_SIZE  slot i = buf_flat[i*PACKET_SIZE +: PACKET_SIZE]
//  slot_clr   out  BUFFER_SIZE              one-hot, 1-cycle pulse: buffer clears that slot's valid at next edge
//  out_pkt    out  PACKET_SIZE              registered packet (valid bit included, =1 while out_valid)
//  out_valid  out  1                        out_pkt holds a packet
//  out_ready  in   1                        downstream accepts; transfer when out_valid & out_ready
//  out_slot   out  PTR_LEN                  slot index out_pkt was taken from
//  occ_cnt    out  PTR_LEN+1                combinational popcount of slot valid bits
// BEHAVIOUR
//  Reset (async assert, sync release): out_pkt=0, out_valid=0, out_slot=0, slot_clr=0, rr_ptr=0, state=IDLE.
//   A packet held at reset is lost; the buffer is reset by its own logic.
//  Selection (comb): first slot with valid=1 scanning rr_ptr, rr_ptr+1, ... wrapping mod BUFFER_SIZE; sel_vld=|valid.
//  FSM IDLE:
//   - sel_vld=0: stay; outputs hold (out_valid=0).
//   - sel_vld=1: at edge: out_pkt<=slot[sel], out_slot<=sel, out_valid<=1.
//     Also slot_clr<=onehot(sel) for exactly 1 cycle, rr_ptr<=sel+1 (wraps), ->SEND.
//  FSM SEND:
//   - out_valid=1, out_pkt/out_slot stable until handshake; out_ready may toggle freely.
//   - out_ready=0: stay. out_ready=1: transfer at edge; out_valid<=0, ->IDLE.
//   - No new selection in SEND; the slot being drained is cleared by the buffer one edge after capture.
//  Latency: slot valid seen in IDLE -> out_valid 1 cycle later. Throughput 1 pkt / 2 cycles (macro off).
//  slot_clr: never more than one bit set; never asserted in a cycle without a preceding capture edge.
//  Simultaneous write of a new packet into another slot during SEND: ignored until next IDLE scan.
//  Slot re-filled by the allocator after clear: eligible like any other; round-robin prevents starvation.
//  All slots full: occ_cnt=BUFFER_SIZE; drain continues normally. All empty: occ_cnt=0, stays IDLE.
// CONFIGURATION
//  RING_DRAIN_B2B_EN defined: in SEND with out_ready=1 the block may reload in the same edge.
//   - Reload only if any valid slot other than out_slot (masked; its clear is in flight).
//   - Reload obeys the IDLE rules (capture, slot_clr pulse, rr_ptr update); out_valid stays 1, state stays SEND.
//   - Sustained throughput 1 pkt/cycle.
//   - The masked slot is ineligible only in that cycle.
//  RING_DRAIN_B2B_EN undefined: behaviour exactly as in BEHAVIOUR; always returns to IDLE after a transfer.
// TESTING
//  T1 reset: rst_n=0 mid-SEND with slot 2 valid -> out_valid,slot_clr,out_slot=0 immediately, rr_ptr=0 after release.
//  T2 single: slot1 valid=1, payload 0x0AB, ready=1 -> out_valid next cycle, out_pkt payload 0x0AB.
//     Also out_slot=1, slot_clr=4'b0010 for 1 cycle.
//  T3 round-robin: all 4 slots valid, refilled on clear, ready=1 -> drain order 0,1,2,3,0.
//     No slot selected twice before others.
//  T4 backpressure: slot3 valid, ready=0 for 5 cycles -> out_pkt/out_slot stable, slot_clr pulses once.
//     Transfer on first ready=1.
//  T5 wrap/empty: rr_ptr=3, only slot0 valid -> selects 0, rr_ptr=1.
//     Then no slots valid -> IDLE, out_valid=0, occ_cnt=0.
//  T6 B2B (macro on): slots 0,1,2 valid, ready=1 -> out_valid held 3 consecutive cycles, out_slot 0,1,2.
//     Macro off: out_valid pattern 1,0,1,0,1.

Source files
------------

// File: rtl/ring_buffer_drain.sv
// ring_buffer_drain: round-robin read side of the ring-router input buffer.
// Optional RING_DRAIN_B2B_EN: reload on the transfer edge for 1 pkt/cycle throughput.
module ring_buffer_drain #(
  parameter int BUFFER_SIZE = 4,
  parameter int PACKET_SIZE = 49,
  parameter int PTR_LEN     = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [BUFFER_SIZE*PACKET_SIZE-1:0] buf_flat,
  output logic [BUFFER_SIZE-1:0]             slot_clr,
  output logic [PACKET_SIZE-1:0]             out_pkt,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [PTR_LEN-1:0]                 out_slot,
  output logic [PTR_LEN:0]                   occ_cnt
);

  if (BUFFER_SIZE != 2**PTR_LEN) begin : g_size_chk
    $error("ring_buffer_drain: BUFFER_SIZE must equal 2**PTR_LEN");
  end

  typedef enum logic {IDLE, SEND} state_t;

  state_t                 state_q, state_d;
  logic [PACKET_SIZE-1:0] out_pkt_q, out_pkt_d;
  logic [PTR_LEN-1:0]     out_slot_q, out_slot_d;
  logic                   out_valid_q, out_valid_d;
  logic [BUFFER_SIZE-1:0] slot_clr_q, slot_clr_d;
  logic [PTR_LEN-1:0]     rr_ptr_q, rr_ptr_d;

  logic [PACKET_SIZE-1:0] slot [BUFFER_SIZE];
  logic [BUFFER_SIZE-1:0] slot_vld;
  logic [BUFFER_SIZE-1:0] elig;
  logic                   sel_vld;
  logic [PTR_LEN-1:0]     sel;
  logic [PTR_LEN-1:0]     idx;

  for (genvar i = 0; i < BUFFER_SIZE; i++) begin : g_slot
    assign slot[i]     = buf_flat[i*PACKET_SIZE +: PACKET_SIZE];
    assign slot_vld[i] = slot[i][PACKET_SIZE-1];
  end

`ifdef RING_DRAIN_B2B_EN
  // The slot held in SEND is still visible in the buffer until its clear lands.
  assign elig = (state_q == SEND) ? (slot_vld & ~(BUFFER_SIZE'(1) << out_slot_q)) : slot_vld;
`else
  assign elig = slot_vld;
`endif

  // First eligible slot at or after rr_ptr, wrapping.
  always_comb begin
    sel_vld = 1'b0;
    sel     = '0;
    idx     = '0;
    for (int i = 0; i < BUFFER_SIZE; i++) begin
      idx = rr_ptr_q + PTR_LEN'(i);
      if (!sel_vld && elig[idx]) begin
        sel_vld = 1'b1;
        sel     = idx;
      end
    end
  end

  always_comb begin
    occ_cnt = '0;
    for (int i = 0; i < BUFFER_SIZE; i++) occ_cnt = occ_cnt + (PTR_LEN+1)'(slot_vld[i]);
  end

  always_comb begin
    state_d     = state_q;
    out_pkt_d   = out_pkt_q;
    out_slot_d  = out_slot_q;
    out_valid_d = out_valid_q;
    slot_clr_d  = '0;
    rr_ptr_d    = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (sel_vld) begin
          out_pkt_d   = slot[sel];
          out_slot_d  = sel;
          out_valid_d = 1'b1;
          slot_clr_d  = BUFFER_SIZE'(1) << sel;
          rr_ptr_d    = sel + PTR_LEN'(1);
          state_d     = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
`ifdef RING_DRAIN_B2B_EN
          if (sel_vld) begin
            out_pkt_d   = slot[sel];
            out_slot_d  = sel;
            out_valid_d = 1'b1;
            slot_clr_d  = BUFFER_SIZE'(1) << sel;
            rr_ptr_d    = sel + PTR_LEN'(1);
            state_d     = SEND;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_pkt_q   <= '0;
      out_slot_q  <= '0;
      out_valid_q <= 1'b0;
      slot_clr_q  <= '0;
      rr_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      out_pkt_q   <= out_pkt_d;
      out_slot_q  <= out_slot_d;
      out_valid_q <= out_valid_d;
      slot_clr_q  <= slot_clr_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_pkt   = out_pkt_q;
  assign out_slot  = out_slot_q;
  assign out_valid = out_valid_q;
  assign slot_clr  = slot_clr_q;

endmodule
